nec_ir_decoder: RTL and testbench

- Receives the demodulated output of the IR receiver module and decodes NEC remote-control frames.
- Presents the 8-bit button command code, held stable, to the drive-mode state machine (IDLE/CAM/IR selection via codes 8'h0f, 8'h13, 8'h10).
- Flags new frames, repeat codes and malformed frames with single-cycle pulses.

---
 rtl/nec_ir_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_nec_ir_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_decoder.sv
// NEC IR remote-control frame decoder.
// Synchronises the demodulated receiver pin, measures mark/space widths in
// clk_50 cycles, and walks lead / 32 data bits / check or repeat code.
// The last good command and address bytes are held for the drive-mode FSM.
module nec_ir_decoder #(
  parameter int UNIT_CYCLES   = 28125,
  parameter int RX_ACTIVE_LOW = 1,
  parameter int CHECK_ADDR    = 1,
  parameter int CNT_W         = 20
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       ir_rx,
  output logic [7:0] ir_code,
  output logic [7:0] ir_addr,
  output logic       code_valid,
  output logic       repeat_pulse,
  output logic       frame_err,
  output logic       busy
);

  // Width thresholds, all in clk_50 cycles.
  localparam logic [CNT_W-1:0] W_HALF = CNT_W'(UNIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] W_1P5  = CNT_W'((3 * UNIT_CYCLES) / 2);
  localparam logic [CNT_W-1:0] W_2P5  = CNT_W'((5 * UNIT_CYCLES) / 2);
  localparam logic [CNT_W-1:0] W_3P5  = CNT_W'((7 * UNIT_CYCLES) / 2);
  localparam logic [CNT_W-1:0] W_3    = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] W_5    = CNT_W'(5 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] W_7    = CNT_W'(7 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] W_9    = CNT_W'(9 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] W_14   = CNT_W'(14 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] W_18   = CNT_W'(18 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] W_TMO  = CNT_W'(20 * UNIT_CYCLES);

  // Pin level while no carrier is present (space).
  localparam logic IDLE_LVL = (RX_ACTIVE_LOW != 0);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LEAD_MARK  = 3'd1;
  localparam logic [2:0] S_LEAD_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK   = 3'd3;
  localparam logic [2:0] S_BIT_SPACE  = 3'd4;
  localparam logic [2:0] S_CHECK      = 3'd5;
  localparam logic [2:0] S_REP_STOP   = 3'd6;

  logic             r_s1, r_s2, r_lvl, r_lvl_d;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_state;
  logic [31:0]      r_sr;
  logic [4:0]       r_idx;
  logic             r_have;
  logic [7:0]       r_code, r_addr;
  logic             r_cv, r_rp, r_fe;

  logic             w_edge, w_mark, w_mark_start, w_tmo, w_frame_ok;
  logic [2:0]       w_nstate;
  logic             w_abort, w_shift, w_bit, w_check, w_repst;

  // Two-flop synchroniser, one level stage, and the edge-detect register.
  // Reset to the idle level so leaving reset never looks like a mark start.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_s1    <= IDLE_LVL;
      r_s2    <= IDLE_LVL;
      r_lvl   <= IDLE_LVL;
      r_lvl_d <= IDLE_LVL;
    end else begin
      r_s1    <= ir_rx;
      r_s2    <= r_s1;
      r_lvl   <= r_s2;
      r_lvl_d <= r_lvl;
    end
  end

  assign w_edge       = r_lvl ^ r_lvl_d;
  assign w_mark       = r_lvl ^ IDLE_LVL;
  assign w_mark_start = w_edge & w_mark;
  assign w_tmo        = (r_cnt == W_TMO);

  // Width counter: cleared on every edge, saturates at the timeout value.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_edge)
      r_cnt <= '0;
    else if (!w_tmo)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Byte layout after 32 LSB-first bits: [7:0] addr, [15:8] ~addr,
  // [23:16] cmd, [31:24] ~cmd.
  assign w_frame_ok = (r_sr[23:16] == ~r_sr[31:24]) &&
                      ((CHECK_ADDR == 0) || (r_sr[7:0] == ~r_sr[15:8]));

  // Next-state and event decode; widths are judged at the edge ending a
  // level, and the timeout only matters when no edge is present.
  always_comb begin
    w_nstate = r_state;
    w_abort  = 1'b0;
    w_shift  = 1'b0;
    w_bit    = 1'b0;
    w_check  = 1'b0;
    w_repst  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mark_start) w_nstate = S_LEAD_MARK;
      end
      S_LEAD_MARK: begin
        if (w_edge) begin
          if (r_cnt >= W_14 && r_cnt <= W_18) w_nstate = S_LEAD_SPACE;
          else                                w_abort  = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      S_LEAD_SPACE: begin
        if (w_edge) begin
          if (r_cnt >= W_7 && r_cnt <= W_9)      w_nstate = S_BIT_MARK;
          else if (r_cnt >= W_3 && r_cnt <= W_5) w_nstate = S_REP_STOP;
          else                                   w_abort  = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      S_BIT_MARK: begin
        if (w_edge) begin
          if (r_cnt >= W_HALF && r_cnt <= W_1P5) w_nstate = S_BIT_SPACE;
          else                                   w_abort  = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      S_BIT_SPACE: begin
        if (w_edge) begin
          if (r_cnt >= W_HALF && r_cnt < W_1P5) begin
            w_shift = 1'b1;
          end else if (r_cnt >= W_2P5 && r_cnt <= W_3P5) begin
            w_shift = 1'b1;
            w_bit   = 1'b1;
          end else begin
            w_abort = 1'b1;
          end
          if (w_shift) w_nstate = (r_idx == 5'd31) ? S_CHECK : S_BIT_MARK;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      S_CHECK: begin
        w_check  = 1'b1;
        w_nstate = w_mark_start ? S_LEAD_MARK : S_IDLE;
      end
      S_REP_STOP: begin
        w_repst  = 1'b1;
        w_nstate = w_mark_start ? S_LEAD_MARK : S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
    if (w_abort) w_nstate = S_IDLE;
  end

  // State, shift register, held code/address and the one-cycle pulses.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_idx   <= '0;
      r_have  <= 1'b0;
      r_code  <= '0;
      r_addr  <= '0;
      r_cv    <= 1'b0;
      r_rp    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cv    <= 1'b0;
      r_rp    <= 1'b0;
      r_fe    <= 1'b0;
      if (w_abort) begin
        r_fe  <= 1'b1;
        r_sr  <= '0;
        r_idx <= '0;
      end else if (w_shift) begin
        r_sr  <= {w_bit, r_sr[31:1]};
        r_idx <= r_idx + 5'd1;      // wraps to 0 after the 32nd bit
      end
      if (w_check) begin
        if (w_frame_ok) begin
          r_code <= r_sr[23:16];
          r_addr <= r_sr[7:0];
          r_cv   <= 1'b1;
          r_have <= 1'b1;
        end else begin
          r_fe   <= 1'b1;
        end
      end
      if (w_repst) begin
        if (r_have) r_rp <= 1'b1;
        else        r_fe <= 1'b1;
      end
    end
  end

  assign ir_code      = r_code;
  assign ir_addr      = r_addr;
  assign code_valid   = r_cv;
  assign repeat_pulse = r_rp;
  assign frame_err    = r_fe;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Bench for nec_ir_decoder: directed NEC frames plus randomized frames with
// jittered timing, judged by a frame-level model of what a receiver should
// report (inverse-byte rule, held code, repeat needs a prior good code).
module tb_nec_ir_decoder;
  localparam int U = 20;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       ir_rx;
  logic [7:0] ir_code, ir_addr;
  logic       code_valid, repeat_pulse, frame_err, busy;

  always #5 clk_50 = ~clk_50;

  nec_ir_decoder #(
    .UNIT_CYCLES(U), .RX_ACTIVE_LOW(1), .CHECK_ADDR(1), .CNT_W(20)
  ) dut (
    .clk_50(clk_50), .reset(reset), .ir_rx(ir_rx),
    .ir_code(ir_code), .ir_addr(ir_addr),
    .code_valid(code_valid), .repeat_pulse(repeat_pulse),
    .frame_err(frame_err), .busy(busy)
  );

  int checks = 0, errors = 0;
  int n_cv = 0, n_rp = 0, n_fe = 0, n_excl = 0;

  // Reference model state.
  logic [7:0] m_code, m_addr;
  bit         m_have;

  // Pulse counters and exclusivity monitor.
  always @(negedge clk_50) begin
    if (code_valid)   n_cv++;
    if (repeat_pulse) n_rp++;
    if (frame_err)    n_fe++;
    if ((code_valid && repeat_pulse) || (code_valid && frame_err) ||
        (repeat_pulse && frame_err)) n_excl++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int jit();
    return int'($urandom_range(8, 0)) - 4;
  endfunction

  // A frame is good when each data byte is followed by its bitwise inverse.
  function automatic bit frame_ok(input logic [31:0] w);
    return (w[31:24] == ~w[23:16]) && (w[15:8] == ~w[7:0]);
  endfunction

  // Drive a mark (pin low) or space (pin high) for n cycles.
  task automatic lvl(input bit mark, input int n);
    ir_rx = mark ? 1'b0 : 1'b1;
    repeat (n) @(negedge clk_50);
  endtask

  task automatic lead_in(input int space_u);
    lvl(1, 16 * U + jit());
    lvl(0, space_u * U + jit());
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      lvl(1, U + jit());
      lvl(0, (w[i] ? 3 * U : U) + jit());
    end
  endtask

  // Stop mark (or post-repeat mark): the outcome pulse must appear exactly
  // 4 clocks after the first sampling edge, and only once.
  task automatic stop_mark(input string tag, input bit e_cv, input bit e_rp, input bit e_fe);
    int cv0, rp0, fe0;
    cv0 = n_cv; rp0 = n_rp; fe0 = n_fe;
    ir_rx = 1'b0;
    repeat (4) @(negedge clk_50);
    chk({tag, "_early"}, {29'd0, code_valid, repeat_pulse, frame_err}, 32'd0);
    @(negedge clk_50);
    chk({tag, "_lat"}, {29'd0, code_valid, repeat_pulse, frame_err},
        {29'd0, e_cv, e_rp, e_fe});
    lvl(1, U - 5);
    lvl(0, 6 * U);
    chk({tag, "_cnt"}, {8'd0, 8'(n_cv - cv0), 8'(n_rp - rp0), 8'(n_fe - fe0)},
        {8'd0, 7'd0, e_cv, 7'd0, e_rp, 7'd0, e_fe});
  endtask

  task automatic send_frame(input string tag, input logic [31:0] w);
    bit ok;
    ok = frame_ok(w);
    lead_in(8);
    send_bits(w, 32);
    stop_mark(tag, ok, 1'b0, !ok);
    if (ok) begin
      m_code = w[23:16];
      m_addr = w[7:0];
      m_have = 1'b1;
    end
    chk({tag, "_code"}, {24'd0, ir_code}, {24'd0, m_code});
    chk({tag, "_addr"}, {24'd0, ir_addr}, {24'd0, m_addr});
  endtask

  task automatic send_repeat(input string tag);
    lead_in(4);
    stop_mark(tag, 1'b0, m_have, !m_have);
    chk({tag, "_code"}, {24'd0, ir_code}, {24'd0, m_code});
  endtask

  initial begin
    int fe0, cv0, rp0;
    logic [31:0] w;
    logic [7:0]  a, c;
    int          kind, k;

    m_code = 8'h00; m_addr = 8'h00; m_have = 1'b0;

    // Reset state
    reset = 1'b1;
    ir_rx = 1'b1;
    repeat (5) @(negedge clk_50);
    chk("rst_regs", {16'd0, ir_code, ir_addr}, 32'd0);
    chk("rst_flags", {28'd0, code_valid, repeat_pulse, frame_err, busy}, 32'd0);
    reset = 1'b0;
    lvl(0, 50);

    // Repeat code with no prior good frame
    send_repeat("t3_rep");

    // Clean frame 00 FF 0F F0
    lead_in(8);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    w = {8'hF0, 8'h0F, 8'hFF, 8'h00};
    send_bits(w, 32);
    stop_mark("t1", 1'b1, 1'b0, 1'b0);
    m_code = 8'h0f; m_addr = 8'h00; m_have = 1'b1;
    chk("t1_code", {24'd0, ir_code}, 32'h0f);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Frame 00 FF 13 EC followed by a repeat code
    send_frame("t2", {8'hEC, 8'h13, 8'hFF, 8'h00});
    send_repeat("t2_rep");
    chk("t2_hold", {24'd0, ir_code}, 32'h13);

    // Bad command inverse
    send_frame("t4", {8'hEE, 8'h10, 8'hFF, 8'h00});
    chk("t4_hold", {24'd0, ir_code}, 32'h13);

    // Short lead mark
    fe0 = n_fe;
    lvl(1, 12 * U);
    lvl(0, 6 * U);
    chk("t5_lead", n_fe - fe0, 1);
    chk("t5_lead_idle", {31'd0, busy}, 32'd0);

    // 2U bit space
    fe0 = n_fe;
    lead_in(8);
    send_bits(32'h0000_0005, 3);
    lvl(1, U);
    lvl(0, 2 * U);
    lvl(1, U);
    lvl(0, 6 * U);
    chk("t5_space", n_fe - fe0, 1);

    // Stuck mark after the lead space: timeout at 20U
    fe0 = n_fe;
    lead_in(8);
    lvl(1, 19 * U);
    chk("t5_tmo_before", n_fe - fe0, 0);
    lvl(1, 2 * U);
    chk("t5_tmo_at", n_fe - fe0, 1);
    lvl(1, 4 * U);
    lvl(0, 6 * U);
    chk("t5_tmo_after", n_fe - fe0, 1);
    chk("t5_hold", {24'd0, ir_code}, {24'd0, m_code});

    // Randomized frames, some with corrupted inverse bytes, some followed
    // by a repeat code
    for (int i = 0; i < 6; i++) begin
      a    = 8'($urandom_range(255, 0));
      c    = 8'($urandom_range(255, 0));
      kind = int'($urandom_range(2, 0));
      k    = int'($urandom_range(7, 0));
      w    = {~c, c, ~a, a};
      if (kind == 1) w[24 + k] = ~w[24 + k];
      if (kind == 2) w[8 + k]  = ~w[8 + k];
      send_frame($sformatf("rnd%0d", i), w);
      if ($urandom_range(1, 0) == 1) send_repeat($sformatf("rnd%0d_rep", i));
    end

    // Reset in the middle of bit 17, then a clean frame
    lead_in(8);
    send_bits({8'hF0, 8'h0F, 8'hFF, 8'h00}, 17);
    cv0 = n_cv; rp0 = n_rp; fe0 = n_fe;
    lvl(1, 10);
    reset = 1'b1;
    ir_rx = 1'b1;
    repeat (3) @(negedge clk_50);
    chk("t6_in_rst", {12'd0, ir_code, ir_addr, code_valid, repeat_pulse, frame_err, busy}, 32'd0);
    repeat (5) @(negedge clk_50);
    reset = 1'b0;
    m_code = 8'h00; m_addr = 8'h00; m_have = 1'b0;
    lvl(0, 8 * U);
    chk("t6_no_pulse", (n_cv - cv0) + (n_rp - rp0) + (n_fe - fe0), 0);
    send_frame("t6", {8'hF0, 8'h0F, 8'hFF, 8'h00});
    chk("t6_code", {24'd0, ir_code}, 32'h0f);

    chk("excl", n_excl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
